// File: rtl/rom_read_arbiter.sv
// Two-port read arbiter in front of a single synchronous-read ROM32x256.
// Define ROM_ARB_FIXED_PRI_EN to replace round-robin with fixed port-0 priority.
module rom_read_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int ROM_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q
);

  logic                   w_gnt0;
  logic                   w_gnt1;
  logic                   w_grant;
  logic                   w_retValid;
  logic                   w_retPort;
  logic [ADDR_W-1:0]      r_lastAddr;
  logic [ROM_LATENCY-1:0] r_tagValid;
  logic [ROM_LATENCY-1:0] r_tagPort;
  logic                   r_rvalid0;
  logic                   r_rvalid1;
  logic [DATA_W-1:0]      r_rdata0;
  logic [DATA_W-1:0]      r_rdata1;

`ifdef ROM_ARB_FIXED_PRI_EN
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!reset) begin
      if (req0)      w_gnt0 = 1'b1;
      else if (req1) w_gnt1 = 1'b1;
    end
  end
`else
  // Last granted port; reset to 1 so port 0 wins the first contention.
  logic r_lastGrant;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        if (r_lastGrant) w_gnt0 = 1'b1;
        else             w_gnt1 = 1'b1;
      end else if (req0) begin
        w_gnt0 = 1'b1;
      end else if (req1) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)        r_lastGrant <= 1'b1;
    else if (w_grant) r_lastGrant <= w_gnt1;
  end
`endif

  assign w_grant = w_gnt0 | w_gnt1;
  assign gnt0    = w_gnt0;
  assign gnt1    = w_gnt1;

  always_comb begin
    rom_address = r_lastAddr;
    if (w_gnt0)      rom_address = addr0;
    else if (w_gnt1) rom_address = addr1;
  end

  always_ff @(posedge clock) begin
    if (reset)        r_lastAddr <= '0;
    else if (w_grant) r_lastAddr <= rom_address;
  end

  // Tag shift register mirrors the ROM pipeline so each word finds its owner.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tagValid <= '0;
      r_tagPort  <= '0;
    end else begin
      r_tagValid[0] <= w_grant;
      r_tagPort[0]  <= w_gnt1;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        r_tagValid[i] <= r_tagValid[i-1];
        r_tagPort[i]  <= r_tagPort[i-1];
      end
    end
  end

  assign w_retValid = r_tagValid[ROM_LATENCY-1];
  assign w_retPort  = r_tagPort[ROM_LATENCY-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_retValid && !w_retPort;
      r_rvalid1 <= w_retValid && w_retPort;
      if (w_retValid && !w_retPort) r_rdata0 <= rom_q;
      if (w_retValid && w_retPort)  r_rdata1 <= rom_q;
    end
  end

  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;

endmodule

// File: doc/rom_read_arbiter.md
Name: rom_read_arbiter

Overview:
- Shares one ROM32x256 instance (synchronous read, registered address) between two read requesters, e.g. instruction fetch (port 0) and constant/data load (port 1).
- Arbitrates round-robin, issues at most one ROM read per cycle and tracks in-flight reads through a tag pipeline.
- Returns each word to the requester that issued it, with a fixed, known latency.
- Sits between the requesters and the ROM; it is the only block that drives the ROM address.

Parameters:
ADDR_W, 8, ROM address width (256 words)
DATA_W, 32, ROM word width
ROM_LATENCY, 1, clocks from address presented to valid rom_q; legal values 1 or 2 (2 = ROM output register enabled)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  port 0 read request; held with addr0 stable until granted
addr0  input  ADDR_W  port 0 word address
gnt0  output  1  port 0 request accepted this cycle (combinational)
rvalid0  output  1  one-cycle pulse: rdata0 holds port 0 read result
rdata0  output  DATA_W  port 0 read data
req1  input  1  port 1 read request
addr1  input  ADDR_W  port 1 word address
gnt1  output  1  port 1 request accepted this cycle
rvalid1  output  1  port 1 read result valid pulse
rdata1  output  DATA_W  port 1 read data
rom_address  output  ADDR_W  to ROM32x256 address
rom_q  input  DATA_W  from ROM32x256 q

Behaviour:
- Reset (synchronous, reset high at clock edge): rvalid0/1=0, rdata0/1=0, in-flight tag pipeline cleared, last_grant=1 (port 0 wins first contention), rom_address register=0.
- gnt0/gnt1 forced to 0 while reset is high.
- Handshake: a transfer occurs on a cycle where reqN=1 and gntN=1. A requester keeps reqN and addrN stable until granted. gnt0 and gnt1 are never high together.
- Arbitration, combinational from req0, req1 and last_grant:
  - Single request: that port is granted.
  - Both requesting: grant the port not equal to last_grant.
  - last_grant updates only on a grant.
- rom_address:
  - Equals the granted port's address in a grant cycle.
  - Otherwise holds the last issued address from a register, so the ROM is not toggled needlessly.
- Tag pipeline: shift register of ROM_LATENCY stages, each holding {valid, port_id}. Stage 0 is loaded on a grant cycle; valid=0 when nothing is granted.
- Return path:
  - When the tag leaves the last stage, rom_q is valid. On that edge the block registers rom_q into rdataN of the tagged port and pulses rvalidN for one cycle.
  - The other port's rdata holds its previous value.
- Latency: grant at edge k, so rvalidN is high in cycle k+ROM_LATENCY+1. The arbiter does not stall; throughput is one read per cycle sustained.
- Back-to-back grants to alternating ports return in issue order, one per cycle.
- Reset mid-operation: all in-flight reads are discarded and no rvalid is produced for them. rdata returns to 0.
- Requester idle (both req low): no grant, tag valid=0, rom_address held.

Optional Feature:
- Macro: ROM_ARB_FIXED_PRI_EN.
- Defined: fixed priority. Port 0 always wins when both request, and last_grant is unused; port 1 can starve under continuous port 0 requests.
- Undefined (default): round-robin as specified above.

Test Plan:
Contents used: ROM address 0 = 32'h01234567, address 1 = 32'h89ABCDEF.
- Reset then req0=1, addr0=0, ROM_LATENCY=1 -> gnt0 high in grant cycle; rvalid0 pulses 2 cycles later with rdata0=32'h01234567; rvalid1 stays 0.
- req0 (addr0=0) and req1 (addr1=1) both held high from the same cycle after reset -> port 0 granted first, port 1 next cycle. rvalid0 then rvalid1 on consecutive cycles, data 32'h01234567 and 32'h89ABCDEF.
- Both ports requesting continuously for 8 cycles -> grants alternate 0,1,0,1..., exactly 4 per port, never gnt0&gnt1.
- ROM_LATENCY=2, req1=1, addr1=1 for one transfer -> rvalid1 high exactly 3 cycles after grant, rdata1=32'h89ABCDEF; rom_address stays 1 afterwards while idle.
- Grant port 0, then assert reset on the next edge -> no rvalid0 pulse, rdata0=0. After reset, the first contention grants port 0.
- With ROM_ARB_FIXED_PRI_EN defined, both ports requesting for 4 cycles -> gnt0 every cycle, gnt1 never.
